fetch_unit: RTL and testbench

- Instruction-fetch stage of the 32-bit MIPS datapath.
- Owns the program counter and issues one word fetch at a time to instruction memory over a valid/ready request channel.
- Captures the returned instruction and presents instruction, PC and PC+4 to the IF/ID boundary under a valid/ready handshake.
- Accepts branch/jump redirects from later stages, squashing any in-flight fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_plus4.sv | 16 +
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } fetchState_t;

  localparam int          INSTR_BYTES   = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  // Clear the byte-offset bits so an address always points at a whole word.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_plus4.sv
// Combinational PC incrementer: adds one instruction width, wrapping at 2^W.
module pc_plus4
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] addr,
  output logic [W-1:0] sum
);

  // Carry out of the top bit is dropped, so the last word wraps to zero.
  always_comb begin
    sum = addr + W'(INSTR_BYTES);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// hands the returned instruction to decode under a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              IMemReqValid,
  input  logic              IMemReqReady,
  output logic [ADDR_W-1:0] IMemReqAddr,
  input  logic              IMemRspValid,
  input  logic [DATA_W-1:0] IMemRspData,
  output logic              IFValid,
  input  logic              IFReady,
  output logic [DATA_W-1:0] IFInstruction,
  output logic [ADDR_W-1:0] IFPC,
  output logic [ADDR_W-1:0] IFPCPlus4
);

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetchState_t       state;
  fetchState_t       nextState;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] redirectAligned;
  logic              squash;

  assign redirectAligned = RedirectPC & PC_ALIGN_MASK[ADDR_W-1:0];

  // One incrementer serves both the PC advance and the IFPCPlus4 capture.
  pc_plus4 #(.W(ADDR_W)) uPcPlus4 (
    .addr (pc),
    .sum  (pcPlus4)
  );

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; a squashed or redirected response sends us back to REQ.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = REQ;
      REQ:  if (IMemReqReady) nextState = WAIT;
      WAIT: if (IMemRspValid) nextState = (squash || Redirect) ? REQ : OUT;
      OUT:  if (Redirect || IFReady) nextState = REQ;
      default: nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from state; the request address is always the PC.
  always_comb begin
    IMemReqValid = (state == REQ);
    IFValid      = (state == OUT);
    IMemReqAddr  = pc;
  end

  // PC, squash flag and IF/ID output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc            <= RESET_PC_ALIGNED;
      squash        <= 1'b0;
      IFInstruction <= DATA_W'(NOP_INSTR);
      IFPC          <= '0;
      IFPCPlus4     <= '0;
    end else begin
      case (state)
        REQ: begin
          if (Redirect) begin
            pc <= redirectAligned;
            if (IMemReqReady) squash <= 1'b1;
          end
        end
        WAIT: begin
          if (Redirect) begin
            pc     <= redirectAligned;
            squash <= 1'b1;
          end
          if (IMemRspValid) begin
            if (squash || Redirect) begin
              squash <= 1'b0;
            end else begin
              IFInstruction <= IMemRspData;
              IFPC          <= pc;
              IFPCPlus4     <= pcPlus4;
              pc            <= pcPlus4;
            end
          end
        end
        OUT: begin
          if (Redirect) pc <= redirectAligned;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A second instance with a
// reset PC at the top of the address space shares all inputs to show wrap.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IMemReqReady;
  logic        IMemRspValid;
  logic [31:0] IMemRspData;
  logic        IFReady;

  logic        reqValid,  wReqValid;
  logic [31:0] reqAddr,   wReqAddr;
  logic        ifValid,   wIfValid;
  logic [31:0] ifInstr,   wIfInstr;
  logic [31:0] ifPC,      wIfPC;
  logic [31:0] ifPCPlus4, wIfPCPlus4;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0040_0000)) dut (
    .Clk(Clk), .Reset(Reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemReqValid(reqValid), .IMemReqReady(IMemReqReady), .IMemReqAddr(reqAddr),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .IFValid(ifValid), .IFReady(IFReady), .IFInstruction(ifInstr),
    .IFPC(ifPC), .IFPCPlus4(ifPCPlus4)
  );

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .Clk(Clk), .Reset(Reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemReqValid(wReqValid), .IMemReqReady(IMemReqReady), .IMemReqAddr(wReqAddr),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .IFValid(wIfValid), .IFReady(IFReady), .IFInstruction(wIfInstr),
    .IFPC(wIfPC), .IFPCPlus4(wIfPCPlus4)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance to just after the next rising edge so sampling avoids the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] target,
                               input logic ready, input logic ifRdy);
    Redirect     = redir;
    RedirectPC   = target;
    IMemReqReady = ready;
    IFReady      = ifRdy;
  endtask

  // Return one instruction word during the current WAIT cycle.
  task automatic respond(input logic [31:0] data);
    IMemRspValid = 1'b1;
    IMemRspData  = data;
    tick();
    IMemRspValid = 1'b0;
    IMemRspData  = 32'h0;
  endtask

  initial begin
    Reset        = 1'b1;
    IMemRspValid = 1'b0;
    IMemRspData  = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    #3 Reset = 1'b0;
    tick();
    tick();

    // Reset state.
    checkOutput("rstReqValid", {31'b0, reqValid}, 32'h0);
    checkOutput("rstReqAddr", reqAddr, 32'h0040_0000);
    checkOutput("rstIfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("rstIfPC", ifPC, 32'h0);
    checkOutput("rstIfPCPlus4", ifPCPlus4, 32'h0);
    checkOutput("rstIfInstr", ifInstr, 32'h0);
    checkOutput("rstWrapAddr", wReqAddr, 32'hFFFF_FFFC);

    // Sequential sweep from the reset PC.
    Reset = 1'b1;
    tick();
    checkOutput("firstReqValid", {31'b0, reqValid}, 32'h1);
    checkOutput("firstReqAddr", reqAddr, 32'h0040_0000);
    tick();
    checkOutput("waitReqValid", {31'b0, reqValid}, 32'h0);
    respond(32'h1111_0000);
    checkOutput("out0Valid", {31'b0, ifValid}, 32'h1);
    checkOutput("out0PC", ifPC, 32'h0040_0000);
    checkOutput("out0PCPlus4", ifPCPlus4, 32'h0040_0004);
    checkOutput("out0Instr", ifInstr, 32'h1111_0000);
    checkOutput("out0ReqValid", {31'b0, reqValid}, 32'h0);
    checkOutput("wrapIfPC", wIfPC, 32'hFFFF_FFFC);
    checkOutput("wrapIfPCPlus4", wIfPCPlus4, 32'h0000_0000);
    tick();
    checkOutput("req1IfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("req1Addr", reqAddr, 32'h0040_0004);
    checkOutput("wrapNextAddr", wReqAddr, 32'h0000_0000);
    tick();
    respond(32'h2222_0000);
    checkOutput("out1Valid", {31'b0, ifValid}, 32'h1);
    checkOutput("out1PC", ifPC, 32'h0040_0004);
    checkOutput("out1PCPlus4", ifPCPlus4, 32'h0040_0008);
    tick();
    tick();
    IFReady = 1'b0;
    respond(32'h3333_0000);
    checkOutput("out2PC", ifPC, 32'h0040_0008);

    // Backpressure: output held while decode stalls.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("holdValid", {31'b0, ifValid}, 32'h1);
      checkOutput("holdPC", ifPC, 32'h0040_0008);
      checkOutput("holdInstr", ifInstr, 32'h3333_0000);
      checkOutput("holdReqValid", {31'b0, reqValid}, 32'h0);
    end
    IFReady = 1'b1;
    tick();
    checkOutput("releaseReqValid", {31'b0, reqValid}, 32'h1);
    checkOutput("releaseReqAddr", reqAddr, 32'h0040_000C);
    checkOutput("releaseIfValid", {31'b0, ifValid}, 32'h0);

    // Redirect an unaccepted request to 0x100, then redirect again in WAIT.
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reqRedirValid", {31'b0, reqValid}, 32'h1);
    checkOutput("reqRedirAddr", reqAddr, 32'h0000_0100);
    IMemReqReady = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("waitRedirAddr", reqAddr, 32'h0000_2000);
    respond(32'hDEAD_0100);
    checkOutput("squashIfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("squashIfPC", ifPC, 32'h0040_0008);
    checkOutput("squashReqValid", {31'b0, reqValid}, 32'h1);
    checkOutput("squashReqAddr", reqAddr, 32'h0000_2000);
    tick();
    respond(32'h2000_AAAA);
    checkOutput("out2000Valid", {31'b0, ifValid}, 32'h1);
    checkOutput("out2000PC", ifPC, 32'h0000_2000);
    checkOutput("out2000Instr", ifInstr, 32'h2000_AAAA);

    // Redirect in OUT with IFReady=1 drops the output and goes to 0x40.
    applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("outRedirIfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("outRedirReqAddr", reqAddr, 32'h0000_0040);

    // Redirect coincident with acceptance at 0x40, target 0x80.
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("coinReqValid", {31'b0, reqValid}, 32'h0);
    checkOutput("coinReqAddr", reqAddr, 32'h0000_0080);
    respond(32'hDEAD_0040);
    checkOutput("coinDropValid", {31'b0, ifValid}, 32'h0);
    checkOutput("coinNextAddr", reqAddr, 32'h0000_0080);
    checkOutput("coinNextReqValid", {31'b0, reqValid}, 32'h1);
    tick();
    respond(32'h8080_0000);
    checkOutput("out80PC", ifPC, 32'h0000_0080);
    checkOutput("out80PCPlus4", ifPCPlus4, 32'h0000_0084);
    checkOutput("out80Instr", ifInstr, 32'h8080_0000);

    // Misaligned redirect target has its low bits cleared.
    applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("alignReqValid", {31'b0, reqValid}, 32'h1);
    checkOutput("alignReqAddr", reqAddr, 32'h0000_0100);

    // Async reset in WAIT, then a stray response after release.
    tick();
    #2 Reset = 1'b0;
    #1;
    checkOutput("asyncReqValid", {31'b0, reqValid}, 32'h0);
    checkOutput("asyncReqAddr", reqAddr, 32'h0040_0000);
    checkOutput("asyncIfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("asyncIfPC", ifPC, 32'h0);
    checkOutput("asyncIfInstr", ifInstr, 32'h0);
    tick();
    Reset        = 1'b1;
    IMemRspValid = 1'b1;
    IMemRspData  = 32'hBAD0_BAD0;
    tick();
    IMemRspValid = 1'b0;
    IMemRspData  = 32'h0;
    checkOutput("strayIfValid", {31'b0, ifValid}, 32'h0);
    checkOutput("strayIfInstr", ifInstr, 32'h0);
    checkOutput("restartReqValid", {31'b0, reqValid}, 32'h1);
    checkOutput("restartReqAddr", reqAddr, 32'h0040_0000);
    tick();
    respond(32'h5555_0000);
    checkOutput("restartIfPC", ifPC, 32'h0040_0000);
    checkOutput("restartIfInstr", ifInstr, 32'h5555_0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
